fetch_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 22 ++
 rtl/fetch_out_reg.sv | 54 +++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: opcodes, canonical NOP and fetch FSM states.
package rv_pkg;

  localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  // Major opcode field of an RV32 instruction word.
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Decode-facing output register with a one-entry skid and flush.
module fetch_out_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            enq_valid,
  input  logic [XLEN-1:0] enq_pc,
  input  logic [XLEN-1:0] enq_instr,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            slot_free,
  output logic            skid_valid
);

  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;

  assign slot_free = !id_valid || id_ready;

  // Output/skid update: flush first, then skid drain, then fresh load or skid capture, then plain consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid && id_ready) begin
      id_valid   <= 1'b1;
      id_pc      <= skid_pc;
      id_instr   <= skid_instr;
      skid_valid <= 1'b0;
    end else if (enq_valid && slot_free) begin
      id_valid <= 1'b1;
      id_pc    <= enq_pc;
      id_instr <= enq_instr;
    end else if (enq_valid) begin
      skid_valid <= 1'b1;
      skid_pc    <= enq_pc;
      skid_instr <= enq_instr;
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: PC, single-outstanding imem requests, redirect handling.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      id_opcode
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            enq_valid;
  logic            slot_free;
  logic            skid_valid;

  assign imem_req_addr = pc;
  assign id_opcode     = opcode_of(id_instr);

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next state, next PC and request/response steering; redirect overrides the normal flow.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    imem_req_valid = 1'b0;
    enq_valid      = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = rst_n;
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          enq_valid = 1'b1;
          if (slot_free) begin
            pc_nxt    = pc + XLEN'(4);
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          pc_nxt    = pc + XLEN'(4);
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    // A stale request still in memory forces a drain before the next request.
    if (redirect_valid) begin
      pc_nxt    = {redirect_pc[XLEN-1:2], 2'b00};
      enq_valid = 1'b0;
      case (state)
        S_REQ:   state_nxt = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_nxt = S_REQ;
        S_DRAIN: state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  fetch_out_reg #(.XLEN(XLEN)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .enq_valid  (enq_valid),
    .enq_pc     (pc),
    .enq_instr  (imem_rsp_data),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .slot_free  (slot_free),
    .skid_valid (skid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle tables plus randomized run against a stream-level model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        rv0, rv1, idv0, idv1;
  logic [31:0] addr0, addr1, pc0, pc1, instr0, instr1;
  logic [6:0]  op0, op1;

  fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rv0), .imem_req_addr(addr0), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(idv0), .id_ready(id_ready), .id_pc(pc0), .id_instr(instr0), .id_opcode(op0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rv1), .imem_req_addr(addr1), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(idv1), .id_ready(id_ready), .id_pc(pc1), .id_instr(instr1), .id_opcode(op1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        idr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [31:0] rdata, input logic redir,
                              input logic [31:0] rpc, input logic idr,
                              input logic e_rv, input logic [31:0] e_addr,
                              input logic e_idv, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir;
    v.rpc = rpc; v.idr = idr; v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_idv = e_idv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  // Instruction image seen by the random phase: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one table row for a cycle, compare mid-cycle, then advance past the edge.
  task automatic run_vec(input vec_t v, input int unsigned sel, input string tag);
    logic        a_rv, a_idv;
    logic [31:0] a_addr, a_pc, a_instr;
    logic [6:0]  a_op;
    logic [6:0]  e_op;
    rst_n = v.rst; imem_req_ready = v.rdy; imem_rsp_valid = v.rv; imem_rsp_data = v.rdata;
    redirect_valid = v.redir; redirect_pc = v.rpc; id_ready = v.idr;
    @(negedge clk);
    if (sel == 0) begin
      a_rv = rv0; a_addr = addr0; a_idv = idv0; a_pc = pc0; a_instr = instr0; a_op = op0;
    end else begin
      a_rv = rv1; a_addr = addr1; a_idv = idv1; a_pc = pc1; a_instr = instr1; a_op = op1;
    end
    e_op = v.e_instr[6:0];
    chk({tag, " req_valid"}, 32'(a_rv), 32'(v.e_rv));
    if (v.e_rv) chk({tag, " req_addr"}, a_addr, v.e_addr);
    chk({tag, " id_valid"}, 32'(a_idv), 32'(v.e_idv));
    if (v.e_idv) begin
      chk({tag, " id_pc"}, a_pc, v.e_pc);
      chk({tag, " id_instr"}, a_instr, v.e_instr);
      chk({tag, " id_opcode"}, 32'(a_op), 32'(e_op));
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];
  vec_t wtbl[$];

  logic        pend;
  logic [31:0] pend_addr;
  int unsigned cnt;
  logic [31:0] exp_pc;
  int unsigned consumed;
  logic        hold_prev;
  logic [31:0] prev_pc, prev_instr;
  logic        acc, rsp_now;
  logic [31:0] acc_addr;

  initial begin
    // Basic stream, back-pressure into skid, redirects in WAIT/REQ/DRAIN, reset mid-WAIT.
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h33,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1, 1,4,1,0,32'h33));
    tbl.push_back(mk(1,0,1,32'h03,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 1,8,1,4,32'h03));
    tbl.push_back(mk(1,0,1,32'h23,0,0,0, 0,0,1,4,32'h03));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,1,4,32'h03));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,1,4,32'h03));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,1,4,32'h03));
    tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,1,4,32'h03));
    tbl.push_back(mk(1,0,0,0,0,0,0, 1,12,1,8,32'h23));
    tbl.push_back(mk(1,1,0,0,0,0,1, 1,12,1,8,32'h23));
    tbl.push_back(mk(1,0,0,0,1,32'h103,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'hDEAD_BEEF,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1, 1,32'h100,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h63,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 1,32'h104,1,32'h100,32'h63));
    tbl.push_back(mk(1,0,1,32'h1111_1111,1,32'h40,0, 0,0,1,32'h100,32'h63));
    tbl.push_back(mk(1,0,0,0,0,0,1, 1,32'h40,0,0,0));
    tbl.push_back(mk(1,1,0,0,1,32'h80,1, 1,32'h40,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h200,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h300,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h2222_2222,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1, 1,32'h300,0,0,0));
    tbl.push_back(mk(1,0,1,32'h33,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h500,1, 1,32'h304,1,32'h300,32'h33));
    tbl.push_back(mk(1,0,0,0,0,0,1, 1,32'h500,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1, 1,32'h500,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, 1,0,0,0,0));

    // PC wrap from 0xFFFF_FFFC and reset while a request is outstanding with id_valid set.
    wtbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
    wtbl.push_back(mk(1,1,0,0,0,0,1, 1,32'hFFFF_FFFC,0,0,0));
    wtbl.push_back(mk(1,0,1,32'h13,0,0,1, 0,0,0,0,0));
    wtbl.push_back(mk(1,1,0,0,0,0,0, 1,32'h0,1,32'hFFFF_FFFC,32'h13));
    wtbl.push_back(mk(0,0,0,0,0,0,0, 0,0,1,32'hFFFF_FFFC,32'h13));
    wtbl.push_back(mk(1,0,0,0,0,0,1, 1,32'hFFFF_FFFC,0,0,0));

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 0, $sformatf("dir%0d", i));

    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < wtbl.size(); i++) run_vec(wtbl[i], 1, $sformatf("wrap%0d", i));

    // Randomized run on dut0: bench acts as memory and tracks the expected fetch stream.
    rst_n = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend = 1'b0; pend_addr = '0; cnt = 0; exp_pc = 32'h0; consumed = 0;
    hold_prev = 1'b0; prev_pc = '0; prev_instr = '0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      imem_rsp_valid = pend && (cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? memf(pend_addr) : $urandom;
      @(negedge clk);
      if (rv0) chk("rnd one_outstanding", 32'(pend), 32'h0);
      if (hold_prev) begin
        chk("rnd hold_valid", 32'(idv0), 32'h1);
        chk("rnd hold_pc", pc0, prev_pc);
        chk("rnd hold_instr", instr0, prev_instr);
      end
      if (idv0 && id_ready) begin
        chk("rnd stream_pc", pc0, exp_pc);
        chk("rnd stream_instr", instr0, memf(pc0));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      hold_prev  = idv0 && !id_ready && !redirect_valid;
      prev_pc    = pc0;
      prev_instr = instr0;
      acc        = rv0 && imem_req_ready;
      acc_addr   = addr0;
      rsp_now    = imem_rsp_valid;
      @(posedge clk); #1;
      if (rsp_now) pend = 1'b0;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        cnt       = $urandom_range(0, 2);
      end else if (pend && cnt > 0) begin
        cnt--;
      end
    end
    checks++;
    if (consumed < 200) begin
      errors++;
      $display("FAIL rnd progress: got %0d instructions expected at least 200", consumed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
